// File: rtl/day11_peak_tracker_if.sv
// Bundle of stream-input, comparator and status signals for day11_peak_tracker.
// The master side feeds samples and comparator results. The slave side is the tracker itself.
interface day11_peak_tracker_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic [3:0]       cmp_a;
    logic [3:0]       cmp_b;
    logic             cmp_g;
    logic             cmp_e;
    logic             cmp_s;
    logic [3:0]       peak;
    logic             peak_valid;
    logic             new_peak;
    logic [CNT_W-1:0] sample_cnt;
    logic [3:0]       eq_cnt;
    logic             err;

    modport master (
        output in_valid, in_data, cmp_g, cmp_e, cmp_s,
        input  in_ready, cmp_a, cmp_b, peak, peak_valid, new_peak,
               sample_cnt, eq_cnt, err
    );

    modport slave (
        input  in_valid, in_data, cmp_g, cmp_e, cmp_s,
        output in_ready, cmp_a, cmp_b, peak, peak_valid, new_peak,
               sample_cnt, eq_cnt, err
    );
endinterface

// File: rtl/day11_peak_tracker.sv
// Streaming 4-bit running-maximum tracker. It sits after an external combinational comparator.
// The tracker drives the comparator operands: a = latched sample, b = current peak.
// It uses the returned g/e/s code to update the peak. It counts samples, pulses on new peaks
// and flags illegal (non-one-hot) comparator codes.
// Optional feature: define PEAK_TRACKER_EQ_COUNT_EN to build the equal-to-peak counter (eq_cnt).
// Without that macro, eq_cnt is tied to zero.
module day11_peak_tracker #(
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    day11_peak_tracker_if.slave    bus
);
    typedef enum logic {IDLE, CMP} state_t;

    state_t           state_reg;
    logic [3:0]       cmp_a_reg;
    logic [3:0]       peak_reg;
    logic             peak_valid_reg;
    logic             new_peak_reg;
    logic             err_reg;
    logic [CNT_W-1:0] sample_cnt_reg;
    logic             code_legal;

    // Exactly one of g/e/s must be set for the comparator result to be trusted.
    assign code_legal = ({bus.cmp_g, bus.cmp_e, bus.cmp_s} == 3'b100) ||
                        ({bus.cmp_g, bus.cmp_e, bus.cmp_s} == 3'b010) ||
                        ({bus.cmp_g, bus.cmp_e, bus.cmp_s} == 3'b001);

    // Accept a new sample only in IDLE, and never while a clear is pending.
    assign bus.in_ready   = (state_reg == IDLE) && !clear;
    assign bus.cmp_a      = cmp_a_reg;
    assign bus.cmp_b      = peak_reg;
    assign bus.peak       = peak_reg;
    assign bus.peak_valid = peak_valid_reg;
    assign bus.new_peak   = new_peak_reg;
    assign bus.sample_cnt = sample_cnt_reg;
    assign bus.err        = err_reg;

    // Two-state accept/compare FSM. In the compare cycle it updates peak, count and error.
    // A clear asserted during CMP aborts the sample because the reset branch wins.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_reg      <= IDLE;
            cmp_a_reg      <= 4'd0;
            peak_reg       <= 4'd0;
            peak_valid_reg <= 1'b0;
            new_peak_reg   <= 1'b0;
            err_reg        <= 1'b0;
            sample_cnt_reg <= '0;
        end else begin
            new_peak_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        cmp_a_reg <= bus.in_data;
                        state_reg <= CMP;
                    end
                end
                CMP: begin
                    state_reg <= IDLE;
                    if (sample_cnt_reg != {CNT_W{1'b1}})
                        sample_cnt_reg <= sample_cnt_reg + 1'b1;
                    if (!code_legal)
                        err_reg <= 1'b1;
                    // The first sample always becomes the peak. The comparator code is then only error-checked.
                    if (!peak_valid_reg) begin
                        peak_reg       <= cmp_a_reg;
                        peak_valid_reg <= 1'b1;
                        new_peak_reg   <= 1'b1;
                    end else if (code_legal && bus.cmp_g) begin
                        peak_reg     <= cmp_a_reg;
                        new_peak_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef PEAK_TRACKER_EQ_COUNT_EN
    logic [3:0] eq_cnt_reg;

    // Count samples equal to the peak. The count restarts at 1 on the first sample,
    // drops to 0 when a larger sample replaces the peak, and saturates at 15.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            eq_cnt_reg <= 4'd0;
        end else if (state_reg == CMP) begin
            if (!peak_valid_reg)
                eq_cnt_reg <= 4'd1;
            else if (code_legal && bus.cmp_g)
                eq_cnt_reg <= 4'd0;
            else if (code_legal && bus.cmp_e && eq_cnt_reg != 4'hF)
                eq_cnt_reg <= eq_cnt_reg + 4'd1;
        end
    end

    assign bus.eq_cnt = eq_cnt_reg;
`else
    assign bus.eq_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_day11_peak_tracker.sv
// Self-checking bench for day11_peak_tracker. It models the upstream 4-bit comparator on cmp_a/cmp_b.
// The bench can corrupt the comparator code on demand.
// A second instance with CNT_W=2 receives the same stream to exercise counter saturation.
module tb_day11_peak_tracker;
    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic bad_code;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    day11_peak_tracker_if #(.CNT_W(8)) bus_a ();
    day11_peak_tracker_if #(.CNT_W(2)) bus_b ();

    day11_peak_tracker #(.CNT_W(8)) dut_a (.clk(clk), .rst(rst), .clear(clear), .bus(bus_a));
    day11_peak_tracker #(.CNT_W(2)) dut_b (.clk(clk), .rst(rst), .clear(clear), .bus(bus_b));

    // Comparator models. On the main instance, bad_code overrides the result with the illegal code 110.
    assign bus_a.cmp_g = bad_code ? 1'b1 : (bus_a.cmp_a >  bus_a.cmp_b);
    assign bus_a.cmp_e = bad_code ? 1'b1 : (bus_a.cmp_a == bus_a.cmp_b);
    assign bus_a.cmp_s = bad_code ? 1'b0 : (bus_a.cmp_a <  bus_a.cmp_b);
    assign bus_b.cmp_g = bus_b.cmp_a >  bus_b.cmp_b;
    assign bus_b.cmp_e = bus_b.cmp_a == bus_b.cmp_b;
    assign bus_b.cmp_s = bus_b.cmp_a <  bus_b.cmp_b;
    assign bus_b.in_valid = bus_a.in_valid;
    assign bus_b.in_data  = bus_a.in_data;

    typedef struct {
        int peak;
        int peak_valid;
        int new_peak;
        int cnt;
        int cnt2;
        int err;
        int eq;
    } exp_t;

    exp_t sb_q[$];

    // Reference state
    int m_peak, m_pv, m_np, m_cnt, m_cnt2, m_err, m_eq;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic model_reset();
        m_peak = 0; m_pv = 0; m_np = 0; m_cnt = 0; m_cnt2 = 0; m_err = 0; m_eq = 0;
    endtask

    task automatic model_sample(input int d, input bit fault);
        exp_t e;
        if (fault) m_err = 1;
        if (m_pv == 0) begin
            m_peak = d; m_pv = 1; m_np = 1; m_eq = 1;
        end else if (!fault && d > m_peak) begin
            m_peak = d; m_np = 1; m_eq = 0;
        end else begin
            m_np = 0;
            if (!fault && d == m_peak && m_eq < 15) m_eq++;
        end
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        e.peak = m_peak; e.peak_valid = m_pv; e.new_peak = m_np;
        e.cnt = m_cnt; e.cnt2 = m_cnt2; e.err = m_err;
`ifdef PEAK_TRACKER_EQ_COUNT_EN
        e.eq = m_eq;
`else
        e.eq = 0;
`endif
        sb_q.push_back(e);
    endtask

    // Wait (bounded) for in_ready. Then hand over one sample and compare the update it produces.
    task automatic send(input int d, input bit fault);
        exp_t e;
        int waited = 0;
        while (!bus_a.in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus_a.in_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        model_sample(d, fault);
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = d[3:0];
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        check("busy_in_cmp", int'(bus_a.in_ready), 0);
        check("cmp_a", int'(bus_a.cmp_a), d);
        bad_code = fault;
        @(posedge clk); #1;
        bad_code = 1'b0;
        e = sb_q.pop_front();
        $display("sample %0h fault=%0b -> peak=%0h new_peak=%0b cnt=%0d cnt2=%0d err=%0b eq=%0d",
                 d, fault, bus_a.peak, bus_a.new_peak, bus_a.sample_cnt, bus_b.sample_cnt,
                 bus_a.err, bus_a.eq_cnt);
        check("peak", int'(bus_a.peak), e.peak);
        check("cmp_b", int'(bus_a.cmp_b), e.peak);
        check("peak_valid", int'(bus_a.peak_valid), e.peak_valid);
        check("new_peak", int'(bus_a.new_peak), e.new_peak);
        check("sample_cnt", int'(bus_a.sample_cnt), e.cnt);
        check("sample_cnt_w2", int'(bus_b.sample_cnt), e.cnt2);
        check("err", int'(bus_a.err), e.err);
        check("eq_cnt", int'(bus_a.eq_cnt), e.eq);
        @(posedge clk); #1;
        check("new_peak_pulse", int'(bus_a.new_peak), 0);
        check("ready_idle", int'(bus_a.in_ready), 1);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_peak"}, int'(bus_a.peak), 0);
        check({tag, "_cmp_a"}, int'(bus_a.cmp_a), 0);
        check({tag, "_cmp_b"}, int'(bus_a.cmp_b), 0);
        check({tag, "_pv"}, int'(bus_a.peak_valid), 0);
        check({tag, "_np"}, int'(bus_a.new_peak), 0);
        check({tag, "_cnt"}, int'(bus_a.sample_cnt), 0);
        check({tag, "_cnt_w2"}, int'(bus_b.sample_cnt), 0);
        check({tag, "_eq"}, int'(bus_a.eq_cnt), 0);
        check({tag, "_err"}, int'(bus_a.err), 0);
    endtask

    initial begin
        int seq[5];
        seq = '{3, 7, 7, 2, 15};
        rst = 1'b1; clear = 1'b0; bad_code = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_data = 4'd0;
        model_reset();

        // Hold reset for two cycles, then check every output
        @(posedge clk); @(posedge clk); #1;
        check_cleared("rst");
        rst = 1'b0;
        #1;
        check("ready_after_rst", int'(bus_a.in_ready), 1);

        // Running maximum over a short stream. The CNT_W=2 copy saturates at 3.
        foreach (seq[i]) send(seq[i], 1'b0);

        // Illegal comparator code: err becomes sticky, peak is held, and the sample is still counted
        send(5, 1'b1);
        send(1, 1'b0);

        // Clear while idle: in_ready drops at once, and everything resets on the edge
        clear = 1'b1;
        #1;
        check("ready_during_clear", int'(bus_a.in_ready), 0);
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        check_cleared("clr");

        // First sample of 0 still sets a new peak, even though the comparator reports equality
        send(0, 1'b0);
        send(4, 1'b0);

        // Clear during the CMP cycle of sample 9 aborts the sample
        bus_a.in_valid = 1'b1;
        bus_a.in_data  = 4'd9;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        check_cleared("abort");
        send(1, 1'b0);
        send(1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
